// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t         : controller FSM encodings
//   fwd_t           : operand source select codes
//   REG_PC          : register that never forwards and never causes a stall
//   load_use_match  : one ID source against the destination of a load in EX
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_HALT     = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_t;

    localparam logic [3:0] REG_PC = 4'd15;

    // R15 reads the PC path, so it can never depend on a pending load.
    function automatic logic load_use_match(input logic [3:0] src,
                                            input logic       use_src,
                                            input logic [3:0] ex_rd);
        return use_src && (src != REG_PC) && (src == ex_rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Operand forwarding select for one ID source operand.
//   src, use_src                 : source register and its valid qualifier
//   ex_* / mem_* / wb_*          : destination and write-enable of each stage
//   ex_load_instr                : EX result not yet available (load)
//   sel                          : 00 RF, 01 EX, 10 MEM, 11 WB
module forward_select
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [3:0] src,
    input  logic       use_src,
    input  logic [3:0] ex_rd,
    input  logic       ex_rf_enable,
    input  logic       ex_load_instr,
    input  logic [3:0] mem_rd,
    input  logic       mem_rf_enable,
    input  logic [3:0] wb_rd,
    input  logic       wb_rf_enable,
    output logic [1:0] sel
);

    // NOTE: assign every combinational output a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        sel = FWD_RF;
        if (use_src && (src != REG_PC)) begin
            // The youngest producer wins; a load in EX has no data yet.
            if (ex_rf_enable && !ex_load_instr && (ex_rd == src))
                sel = FWD_EX;
            else if (mem_rf_enable && (mem_rd == src))
                sel = FWD_MEM;
            else if (wb_rf_enable && (wb_rd == src))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait handling with timeout, and operand forwarding selects.
//   Clk, Clr                     : clock, async active-low reset
//   ID_* / EX_* / MEM_* / WB_*   : register fields and write enables per stage
//   branch_taken, mem_busy       : control events
//   PC_LE, IF_ID_LE, nop_sel,
//   IF_ID_flush, pipe_hold       : pipeline control
//   fwd_A, fwd_B, fwd_D          : operand source selects
//   state, mem_error             : FSM state and sticky timeout flag
//   stall_cnt, flush_cnt         : saturating statistics counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic [3:0]       EX_RD,
    input  logic [3:0]       MEM_RD,
    input  logic [3:0]       WB_RD,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             nop_sel,
    output logic             IF_ID_flush,
    output logic             pipe_hold,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_D,
    output logic [1:0]       state,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state_q, state_d;
    logic [7:0] tmo_q;
    logic       tmo_load, tmo_inc, err_set, stall_inc, flush_inc;
    logic       load_use;

    assign state = state_q;

    assign load_use = EX_load_instr && EX_RF_enable &&
                      (load_use_match(ID_Rn, ID_use_Rn, EX_RD) ||
                       load_use_match(ID_Rm, ID_use_Rm, EX_RD) ||
                       load_use_match(ID_Rd, ID_use_Rd, EX_RD));

    forward_select u_fwd_a (
        .src(ID_Rn), .use_src(ID_use_Rn),
        .ex_rd(EX_RD), .ex_rf_enable(EX_RF_enable), .ex_load_instr(EX_load_instr),
        .mem_rd(MEM_RD), .mem_rf_enable(MEM_RF_enable),
        .wb_rd(WB_RD), .wb_rf_enable(WB_RF_enable),
        .sel(fwd_A)
    );

    forward_select u_fwd_b (
        .src(ID_Rm), .use_src(ID_use_Rm),
        .ex_rd(EX_RD), .ex_rf_enable(EX_RF_enable), .ex_load_instr(EX_load_instr),
        .mem_rd(MEM_RD), .mem_rf_enable(MEM_RF_enable),
        .wb_rd(WB_RD), .wb_rf_enable(WB_RF_enable),
        .sel(fwd_B)
    );

    forward_select u_fwd_d (
        .src(ID_Rd), .use_src(ID_use_Rd),
        .ex_rd(EX_RD), .ex_rf_enable(EX_RF_enable), .ex_load_instr(EX_load_instr),
        .mem_rd(MEM_RD), .mem_rf_enable(MEM_RF_enable),
        .wb_rd(WB_RD), .wb_rf_enable(WB_RF_enable),
        .sel(fwd_D)
    );

    always_comb begin
        state_d     = state_q;
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        nop_sel     = 1'b0;
        IF_ID_flush = 1'b0;
        pipe_hold   = 1'b0;
        tmo_load    = 1'b0;
        tmo_inc     = 1'b0;
        err_set     = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            ST_INIT: begin
                PC_LE       = 1'b0;
                IF_ID_LE    = 1'b0;
                nop_sel     = 1'b1;
                IF_ID_flush = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (mem_busy) begin
                    PC_LE     = 1'b0;
                    IF_ID_LE  = 1'b0;
                    pipe_hold = 1'b1;
                    tmo_load  = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else if (load_use) begin
                    // A stalled branch is re-presented next cycle, so it is
                    // safe to ignore it here.
                    PC_LE     = 1'b0;
                    IF_ID_LE  = 1'b0;
                    nop_sel   = 1'b1;
                    stall_inc = 1'b1;
                end else if (branch_taken) begin
                    IF_ID_flush = 1'b1;
                    flush_inc   = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                stall_inc = 1'b1;
                if (mem_busy) begin
                    PC_LE     = 1'b0;
                    IF_ID_LE  = 1'b0;
                    pipe_hold = 1'b1;
                    tmo_inc   = 1'b1;
                    // tmo_q counts busy cycles before this one; this cycle
                    // brings the total to tmo_q+1.
                    if (({1'b0, tmo_q} + 9'd1) >= 9'(MEM_TIMEOUT)) begin
                        err_set = 1'b1;
                        state_d = ST_HALT;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                PC_LE     = 1'b0;
                IF_ID_LE  = 1'b0;
                pipe_hold = 1'b1;
                nop_sel   = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q   <= ST_INIT;
            tmo_q     <= 8'd0;
            mem_error <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (tmo_load)
                tmo_q <= 8'd1;
            else if (tmo_inc)
                tmo_q <= tmo_q + 8'd1;
            if (err_set)
                mem_error <= 1'b1;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
